// File: rtl/aes_idec_iter_if.sv
// Valid/ready bundle for one ciphertext-in / plaintext-out AES decrypt channel.
// Latency: none, wires only.
// Backpressure: in_ready / out_ready carry stall information in each direction.
//   in_valid/in_ready/in_data    : ciphertext block towards the core
//   out_valid/out_ready/out_data : plaintext block from the core
//   master: block source and result sink; slave: the decrypt core
interface aes_idec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_idec_iter.sv
// Iterative AES-128/192/256 inverse cipher, one inverse round per clock.
// Latency: out_valid rises Nr cycles after the input accept edge (10/12/14).
// Backpressure: result held in DONE until out_ready; a new block is taken on the same edge.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : slave side of the ciphertext/plaintext valid/ready bundle
//   KExp         : expanded key, word w at KExp[32*w +: 32], stable while a block is in flight
//   IBox/EXP3/LN3: inverse S-box, base-3 exp and log tables over GF(2^8)
//   busy         : high while rounds are being applied

// Inverse ShiftRows: row j rotates right by j columns.
module aes_isrow (
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar j = 0; j < 4; j++) begin : g_row
            assign o_data[127-8*(4*c+j) -: 8] = i_data[127-8*(4*((c+4-j)%4)+j) -: 8];
        end
    end
endmodule

// Inverse SubBytes: table lookup per byte.
module aes_isbyte (
    input  logic [255:0][7:0] IBox,
    input  logic [127:0]      i_data,
    output logic [127:0]      o_data
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign o_data[127-8*i -: 8] = IBox[i_data[127-8*i -: 8]];
    end
endmodule

// AddRoundKey: XOR with key words 4*i_index .. 4*i_index+3.
module aes_arkey #(
    parameter int NR = 14
) (
    input  logic [128*(NR+1)-1:0] i_kexp,
    input  logic [3:0]            i_index,
    input  logic [127:0]          i_data,
    output logic [127:0]          o_data
);
    logic [NR:0][127:0] w_rk_all;
    logic [127:0]       w_chunk;

    assign w_rk_all = i_kexp;
    assign w_chunk  = w_rk_all[i_index];
    // Lowest-addressed word of the round key lines up with state bytes 0..3 (MSBs).
    assign o_data   = i_data ^ {w_chunk[31:0], w_chunk[63:32], w_chunk[95:64], w_chunk[127:96]};
endmodule

// Inverse MixColumns using log/antilog tables for the GF(2^8) products.
module aes_imcol (
    input  logic [255:0][7:0] EXP3,
    input  logic [255:0][7:0] LN3,
    input  logic [127:0]      i_data,
    output logic [127:0]      o_data
);
    // Row 0 of the inverse mix matrix; row j is this rotated right by j.
    localparam logic [3:0][7:0] COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    // log(a) + log(b) modulo 255; logs are 0..254 so one subtraction suffices.
    function automatic logic [7:0] f_addmod(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 9'd255) begin
            s = s - 9'd255;
        end
        return s[7:0];
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar j = 0; j < 4; j++) begin : g_row
            logic [3:0][7:0] w_p;
            for (genvar k = 0; k < 4; k++) begin : g_term
                logic [7:0] w_a;
                assign w_a    = i_data[127-8*(4*c+k) -: 8];
                // Zero has no logarithm; its product is forced to zero.
                assign w_p[k] = (w_a == 8'h00) ? 8'h00 :
                                EXP3[f_addmod(LN3[w_a], LN3[COEF[(k-j+4)%4]])];
            end
            assign o_data[127-8*(4*c+j) -: 8] = w_p[0] ^ w_p[1] ^ w_p[2] ^ w_p[3];
        end
    end
endmodule

module aes_idec_iter #(
    parameter int KEY_BITS = 256,
    parameter int Nb       = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    aes_idec_iter_if.slave                       bus,
    input  logic [32*Nb*(KEY_BITS/32+7)-1:0]     KExp,
    input  logic [255:0][7:0]                    IBox,
    input  logic [255:0][7:0]                    EXP3,
    input  logic [255:0][7:0]                    LN3,
    output logic                                 busy
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
        $fatal(1, "aes_idec_iter: KEY_BITS must be 128, 192 or 256");
    end
    if (Nb != 4) begin : g_bad_nb
        $fatal(1, "aes_idec_iter: Nb must be 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state;
    logic [127:0] r_out_data;
    logic [3:0]   r_round;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;
    logic         w_load;

    logic [127:0] w_ark_init;
    logic [127:0] w_isrow;
    logic [127:0] w_isbyte;
    logic [127:0] w_ark;
    logic [127:0] w_imcol;
    logic [127:0] w_round_out;

    // Whitening with the last round key as the block is accepted.
    aes_arkey #(.NR(NR)) u_ark_init (
        .i_kexp  (KExp),
        .i_index (4'(NR)),
        .i_data  (bus.in_data),
        .o_data  (w_ark_init)
    );

    aes_isrow u_isrow (
        .i_data (r_state),
        .o_data (w_isrow)
    );

    aes_isbyte u_isbyte (
        .IBox   (IBox),
        .i_data (w_isrow),
        .o_data (w_isbyte)
    );

    aes_arkey #(.NR(NR)) u_ark_round (
        .i_kexp  (KExp),
        .i_index (r_round),
        .i_data  (w_isbyte),
        .o_data  (w_ark)
    );

    aes_imcol u_imcol (
        .EXP3   (EXP3),
        .LN3    (LN3),
        .i_data (w_ark),
        .o_data (w_imcol)
    );

    // Round 0 is the final inverse round and skips InvMixColumns.
    assign w_round_out = (r_round == 4'd0) ? w_ark : w_imcol;

    assign w_load = bus.in_valid & w_in_ready;

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_fsm_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_round == 4'd0) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                // The slot frees as the result leaves, so a waiting block goes
                // straight into RUN with no idle cycle in between.
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    w_fsm_nxt = bus.in_valid ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm      <= S_IDLE;
            r_state    <= '0;
            r_out_data <= '0;
            r_round    <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_load) begin
                r_state <= w_ark_init;
                r_round <= 4'(NR - 1);
            end else if (r_fsm == S_RUN) begin
                r_state <= w_round_out;
                if (r_round != 4'd0) begin
                    r_round <= r_round - 4'd1;
                end else begin
                    r_out_data <= w_round_out;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = w_busy;
endmodule

// File: tb/tb_aes_idec_iter.sv
// Bench for aes_idec_iter: one instance per key size, FIPS-197 known-answer vectors.
// Stimulus pushes expected plaintext and latency into a scoreboard queue;
// a monitor pops and compares whenever an instance presents out_valid.
module tb_aes_idec_iter;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] JUNK   = 128'hdeadbeef_0badf00d_5555aaaa_12345678;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]        sbox [256];
    logic [255:0][7:0] ibox, exp3, ln3;
    logic [1407:0]     kexp128;
    logic [1663:0]     kexp192;
    logic [1919:0]     kexp256;

    logic [2:0]   drv_vld;
    logic [2:0]   drv_ordy;
    logic [127:0] drv_dat [3];

    aes_idec_iter_if bus0 ();
    aes_idec_iter_if bus1 ();
    aes_idec_iter_if bus2 ();

    wire b0, b1, b2;

    assign bus0.in_valid = drv_vld[0];  assign bus0.in_data = drv_dat[0];  assign bus0.out_ready = drv_ordy[0];
    assign bus1.in_valid = drv_vld[1];  assign bus1.in_data = drv_dat[1];  assign bus1.out_ready = drv_ordy[1];
    assign bus2.in_valid = drv_vld[2];  assign bus2.in_data = drv_dat[2];  assign bus2.out_ready = drv_ordy[2];

    wire [2:0] mon_ir   = {bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
    wire [2:0] mon_ov   = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    wire [2:0] mon_busy = {b2, b1, b0};
    wire [127:0] mon_od [3];
    assign mon_od[0] = bus0.out_data;
    assign mon_od[1] = bus1.out_data;
    assign mon_od[2] = bus2.out_data;

    aes_idec_iter #(.KEY_BITS(128)) u128 (
        .clock(clock), .reset(reset), .bus(bus0), .KExp(kexp128),
        .IBox(ibox), .EXP3(exp3), .LN3(ln3), .busy(b0));
    aes_idec_iter #(.KEY_BITS(192)) u192 (
        .clock(clock), .reset(reset), .bus(bus1), .KExp(kexp192),
        .IBox(ibox), .EXP3(exp3), .LN3(ln3), .busy(b1));
    aes_idec_iter #(.KEY_BITS(256)) u256 (
        .clock(clock), .reset(reset), .bus(bus2), .KExp(kexp256),
        .IBox(ibox), .EXP3(exp3), .LN3(ln3), .busy(b2));

    typedef struct {
        int           k;
        logic [127:0] dat;
        int           acc;
        int           lat;
    } exp_t;
    exp_t q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference tables and key schedule ----------------
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    task automatic build_tables();
        logic [7:0] x, inv, s;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp3[i] = x;
            ln3[x]  = 8'(i);
            x       = x ^ xt(x);
        end
        exp3[255] = x;
        ln3[0]    = 8'h00;
        for (int i = 0; i < 256; i++) begin
            inv = (i == 0) ? 8'h00 : exp3[(255 - int'(ln3[i])) % 255];
            s   = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[i] = s;
            ibox[s] = 8'(i);
        end
    endtask

    task automatic expand(input int nk, output logic [1919:0] kx);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        kx = '0;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            kx[32*i +: 32] = w[i];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input int k, input logic [127:0] d, input logic [127:0] e, output int waits);
        drv_vld[k] = 1'b1;
        drv_dat[k] = d;
        waits = 0;
        @(negedge clock);
        while (!mon_ir[k] && waits < 100) begin
            @(negedge clock);
            waits++;
        end
        if (!mon_ir[k]) fail_now($sformatf("accept_timeout dut%0d", k));
        else q.push_back('{k, e, cyc + 1, 10 + 2 * k});
        @(posedge clock);
        #1;
        drv_vld[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        @(posedge clock);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [2:0] held = 3'b000;

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (mon_ov[k]) begin
                if (q.size() == 0) begin
                    fail_now($sformatf("unexpected_out_valid dut%0d", k));
                end else begin
                    if (!held[k]) begin
                        chk($sformatf("result_source dut%0d", k), q[0].k, k);
                        chk($sformatf("latency dut%0d", k), cyc - q[0].acc, q[0].lat);
                    end
                    chk($sformatf("out_data dut%0d", k), mon_od[k], q[0].dat);
                    if (drv_ordy[k]) void'(q.pop_front());
                end
            end
            held[k] = mon_ov[k] & ~drv_ordy[k];
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        logic [1919:0] kx;
        drv_vld  = 3'b000;
        drv_ordy = 3'b111;
        for (int k = 0; k < 3; k++) drv_dat[k] = '0;
        build_tables();
        expand(4, kx); kexp128 = kx[1407:0];
        expand(6, kx); kexp192 = kx[1663:0];
        expand(8, kx); kexp256 = kx;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_in_ready dut%0d", k),  mon_ir[k],   1);
            chk($sformatf("reset_out_valid dut%0d", k), mon_ov[k],   0);
            chk($sformatf("reset_busy dut%0d", k),      mon_busy[k], 0);
            chk($sformatf("reset_out_data dut%0d", k),  mon_od[k],   0);
        end
        @(posedge clock);
        #1;

        // AES-128, AES-192, AES-256 known answers
        send(0, CT128, PT, w); drain();
        send(1, CT192, PT, w); drain();
        send(2, CT256, PT, w); drain();

        // AES-256 result held for 20 cycles, then leaves as the next block enters
        drv_ordy[2] = 1'b0;
        send(2, CT256, PT, w);
        w = 0;
        @(negedge clock);
        while (!mon_ov[2] && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!mon_ov[2]) fail_now("hold_wait_timeout");
        for (int i = 0; i < 20; i++) begin
            chk("hold_in_ready", mon_ir[2], 0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        drv_ordy[2] = 1'b1;
        send(2, CT256, PT, w);
        chk("same_edge_accept_waits", w, 0);
        drain();

        // AES-128 reset in the middle of RUN
        send(0, CT128, PT, w);
        repeat (5) @(posedge clock);
        #1;
        chk("busy_before_reset", mon_busy[0], 1);
        reset = 1'b1;
        q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("post_reset_in_ready", mon_ir[0], 1);
        chk("post_reset_out_valid", mon_ov[0], 0);
        chk("post_reset_busy", mon_busy[0], 0);
        @(posedge clock);
        #1;
        send(0, CT128, PT, w);
        drain();

        // AES-128 with junk offered while busy
        send(0, CT128, PT, w);
        repeat (2) @(posedge clock);
        #1;
        drv_vld[0] = 1'b1;
        drv_dat[0] = JUNK;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("busy_in_ready", mon_ir[0], 0);
            chk("busy_flag", mon_busy[0], 1);
        end
        @(posedge clock);
        #1;
        drv_vld[0] = 1'b0;
        drain();

        repeat (5) @(posedge clock);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
